// File: rtl/cu_isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cu_isa_pkg
//  Brief    : Shared ISA constants for the compute unit: word and address
//             widths, opcode encodings, instruction field offsets and the
//             fetch-stage state type.
//  Revision : 1.0  initial release
// ============================================================================
package cu_isa_pkg;

    // Datapath geometry
    localparam int INST_WIDTH   = 16;
    localparam int ADDR_WIDTH   = 5;
    localparam int PC_STEP      = 2;

    // Instruction field offsets: opcode in the top nibble, operand below it
    localparam int OPCODE_WIDTH = 4;
    localparam int OPCODE_MSB   = INST_WIDTH - 1;
    localparam int OPCODE_LSB   = INST_WIDTH - OPCODE_WIDTH;
    localparam int OPERAND_MSB  = OPCODE_LSB - 1;
    localparam int OPERAND_LSB  = 0;

    // Opcode encodings
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 4'b0001;
    localparam logic [OPCODE_WIDTH-1:0] OP_ST   = 4'b0010;
    localparam logic [OPCODE_WIDTH-1:0] OP_PUSH = 4'b0100;
    localparam logic [OPCODE_WIDTH-1:0] OP_PULL = 4'b0101;
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 4'b1111;

    // Fetch-stage state, explicitly encoded
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_reg
//  Brief    : IF/ID pipeline register with a valid/ready output handshake.
//             Holds one instruction and its byte address. A load overwrites
//             the contents (even while a transfer completes the same edge),
//             a clear or a completed transfer empties it, otherwise it holds.
//  Revision : 1.0  initial release
// ============================================================================
module if_id_reg #(
    parameter int INST_WIDTH = cu_isa_pkg::INST_WIDTH,
    parameter int ADDR_WIDTH = cu_isa_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [INST_WIDTH-1:0] i_instr,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [INST_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    logic                  r_valid;
    logic [INST_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  w_drain;

    // A held entry leaves the register when the consumer is ready
    assign w_drain = r_valid && i_ready;

    // Load has priority; clear/drain only drop valid so the payload stays stable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_clear || w_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Brief    : PC / fetch stage. Drives the byte address into a combinational
//             instruction ROM, forwards each returned word through the IF/ID
//             register to the decoder, and stops on a HALT opcode, which is
//             consumed rather than forwarded. Reports done once halted and
//             drained.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch #(
    parameter int                                  INST_WIDTH  = cu_isa_pkg::INST_WIDTH,
    parameter int                                  ADDR_WIDTH  = cu_isa_pkg::ADDR_WIDTH,
    parameter int                                  PC_STEP     = cu_isa_pkg::PC_STEP,
    parameter logic [cu_isa_pkg::OPCODE_WIDTH-1:0] HALT_OPCODE = cu_isa_pkg::OP_HALT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [INST_WIDTH-1:0] inst_in,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [INST_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  busy,
    output logic                  done
);

    import cu_isa_pkg::*;

    // PC arithmetic wraps naturally at 2^ADDR_WIDTH
    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP  = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] c_PC_RESET = '0;

    fetch_state_e            r_state;
    fetch_state_e            w_state_next;
    logic [ADDR_WIDTH-1:0]   r_pc;

    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic                    w_is_halt;
    logic                    w_load;
    logic                    w_fwd;
    logic                    w_consume_halt;
    logic                    w_restart;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_if_valid;
    logic [INST_WIDTH-1:0]   w_if_instr;
    logic [ADDR_WIDTH-1:0]   w_if_pc;

    // The ROM answers in the same cycle, so the opcode is decoded straight off inst_in
    assign w_opcode = inst_in[INST_WIDTH-1 -: OPCODE_WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start is only honoured outside FETCH
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                if (w_consume_halt) begin
                    w_state_next = HALTED;
                end
            end
            HALTED: begin
                if (start) begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output / control decode from the registered state
    always_comb begin
        w_is_halt      = (w_opcode == HALT_OPCODE);
        w_busy         = (r_state != IDLE);
        w_done         = (r_state == HALTED) && !w_if_valid;
        // A slot is free when the register is empty or is being emptied this edge
        w_load         = (r_state == FETCH) && (!w_if_valid || if_ready);
        w_fwd          = w_load && !w_is_halt;
        w_consume_halt = w_load && w_is_halt;
        w_restart      = start && ((r_state == IDLE) || (r_state == HALTED));
    end

    // Program counter: reload on (re)start, advance on every forwarded word, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= c_PC_RESET;
        end else if (w_restart) begin
            r_pc <= c_PC_RESET;
        end else if (w_fwd) begin
            r_pc <= r_pc + c_PC_STEP;
        end
    end

    // A consumed HALT never enters the register; clearing it drops any entry
    // that is being transferred on the same edge.
    if_id_reg #(
        .INST_WIDTH (INST_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_fwd),
        .i_clear (w_consume_halt),
        .i_instr (inst_in),
        .i_pc    (r_pc),
        .i_ready (if_ready),
        .o_valid (w_if_valid),
        .o_instr (w_if_instr),
        .o_pc    (w_if_pc)
    );

    assign read_addr = r_pc;
    assign if_valid  = w_if_valid;
    assign if_instr  = w_if_instr;
    assign if_pc     = w_if_pc;
    assign busy      = w_busy;
    assign done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Brief    : Self-checking bench for instruction_fetch. A behavioural ROM
//             walk predicts the instruction stream the decoder must receive;
//             a monitor pops and compares on every valid/ready transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

    typedef struct packed {
        logic [15:0] instr;
        logic [4:0]  pc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  read_addr;
    logic [15:0] inst_in;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [4:0]  if_pc;
    logic        busy;
    logic        done;

    logic [15:0] rom [16];
    item_t       exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    logic        prev_stall = 1'b0;
    logic [15:0] prev_instr;
    logic [4:0]  prev_pc;

    instruction_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .read_addr (read_addr),
        .inst_in   (inst_in),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Combinational ROM, word-indexed by the byte address
    assign inst_in = rom[read_addr[4:1]];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: walk the ROM from address 0, forwarding every word until the first HALT
    task automatic build_expect();
        item_t e;
        for (int a = 0; a < 16; a++) begin
            if (rom[a][15:12] == 4'hF) break;
            e.instr = rom[a];
            e.pc    = 5'(2 * a);
            exp_q.push_back(e);
        end
    endtask

    task automatic load_basic_program();
        rom[0] = {4'b0001, 12'($urandom)};
        rom[1] = {4'b0010, 12'($urandom)};
        rom[2] = {4'b0100, 12'($urandom)};
        rom[3] = {4'b1111, 12'($urandom)};
        for (int a = 4; a < 16; a++) rom[a] = 16'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_read_addr"}, 32'(read_addr), 32'd0);
        chk({tag, "_if_valid"},  32'(if_valid),  32'd0);
        chk({tag, "_if_instr"},  32'(if_instr),  32'd0);
        chk({tag, "_if_pc"},     32'(if_pc),     32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        for (int i = 0; i < budget; i++) begin
            step();
            if (done) break;
            if (rnd) if_ready = ($urandom_range(0, 3) != 0);
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    // Monitor: score every transfer, and check that a stalled entry holds still
    always @(negedge clk) begin
        item_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(if_valid), 32'd1);
                chk("stall_instr", 32'(if_instr), 32'(prev_instr));
                chk("stall_pc",    32'(if_pc),    32'(prev_pc));
            end
            if (if_valid) chk("halt_not_forwarded", 32'(if_instr[15:12] == 4'hF), 32'd0);
            if (if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_transfer: got pc %h instr %h, required no transfer (t=%0t)",
                             if_pc, if_instr, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_instr", 32'(if_instr), 32'(e.instr));
                    chk("xfer_pc",    32'(if_pc),    32'(e.pc));
                end
            end
            prev_stall = if_valid && !if_ready;
            prev_instr = if_instr;
            prev_pc    = if_pc;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        item_t e;
        int    h;

        rst      = 1'b1;
        start    = 1'b0;
        if_ready = 1'b1;
        for (int a = 0; a < 16; a++) rom[a] = 16'h0000;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;

        // 1: straight-line program, decoder always ready
        load_basic_program();
        build_expect();
        pulse_start();
        chk("t1_busy_after_start",  32'(busy),     32'd1);
        chk("t1_valid_after_start", 32'(if_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_valid",     32'(if_valid),  32'd1);
            chk("t1_pc",        32'(if_pc),     32'(2 * i));
            chk("t1_read_addr", 32'(read_addr), 32'(2 * i + 2));
        end
        step();
        chk("t1_done",       32'(done),         32'd1);
        chk("t1_valid_end",  32'(if_valid),     32'd0);
        chk("t1_busy_end",   32'(busy),         32'd1);
        chk("t1_q_empty",    32'(exp_q.size()), 32'd0);

        // 2: same program, decoder stalls three cycles on ST
        load_basic_program();
        build_expect();
        pulse_start();
        step();
        step();
        chk("t2_st_pc", 32'(if_pc), 32'd2);
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_hold_valid", 32'(if_valid),  32'd1);
            chk("t2_hold_pc",    32'(if_pc),     32'd2);
            chk("t2_hold_instr", 32'(if_instr),  32'(rom[1]));
            chk("t2_hold_raddr", 32'(read_addr), 32'd4);
        end
        if_ready = 1'b1;
        wait_done(20, 1'b0);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: no HALT, PC wraps past 30 and fetch continues
        for (int a = 0; a < 16; a++) rom[a] = {4'($urandom_range(0, 14)), 12'($urandom)};
        for (int i = 0; i < 18; i++) begin
            e.instr = rom[i % 16];
            e.pc    = 5'((2 * i) % 32);
            exp_q.push_back(e);
        end
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            step();
            chk("t3_busy", 32'(busy), 32'd1);
            if (exp_q.size() == 0) break;
        end
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: reset mid-run with an entry held; start ignored while in reset
        chk("t4_pre_rst_valid", 32'(if_valid), 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        step();
        chk_reset_vals("t4_rst");
        step();
        chk("t4_busy_rst_start", 32'(busy), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk("t4_busy_after", 32'(busy),     32'd0);
        chk("t4_valid_after", 32'(if_valid), 32'd0);

        // 5: start during FETCH ignored; start in HALTED refetches from 0
        load_basic_program();
        build_expect();
        pulse_start();
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_busy_fetch", 32'(busy), 32'd1);
        wait_done(20, 1'b0);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
        build_expect();
        start = 1'b1;
        chk("t5_done_before", 32'(done), 32'd1);
        step();
        start = 1'b0;
        chk("t5_done_fell",   32'(done),      32'd0);
        chk("t5_busy_refetch", 32'(busy),     32'd1);
        chk("t5_raddr_reload", 32'(read_addr), 32'd0);
        wait_done(20, 1'b0);
        chk("t5_q_empty2", 32'(exp_q.size()), 32'd0);

        // 6: HALT at address 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        rom[0] = {4'hF, 12'($urandom)};
        pulse_start();
        chk("t6_done_early",  32'(done),     32'd0);
        chk("t6_valid_early", 32'(if_valid), 32'd0);
        step();
        chk("t6_done", 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_valid_never", 32'(if_valid),  32'd0);
            chk("t6_raddr_hold",  32'(read_addr), 32'd0);
        end

        // 7: random programs with random decoder back-pressure
        for (int t = 0; t < 25; t++) begin
            h = $urandom_range(0, 15);
            for (int a = 0; a < 16; a++) begin
                if (a < h)       rom[a] = {4'($urandom_range(0, 14)), 12'($urandom)};
                else if (a == h) rom[a] = {4'hF, 12'($urandom)};
                else             rom[a] = 16'($urandom);
            end
            build_expect();
            pulse_start();
            wait_done(300, 1'b1);
            chk("t7_q_empty", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
